btn_debounce: RTL and testbench

//   Turns a raw, asynchronous, bouncing push-button input into clean single-cycle events.

---
 rtl/super_counter_pkg.sv | 13 +
 rtl/btn_debounce_sync_2ff.sv | 24 ++
 rtl/btn_debounce.sv | 177 +++++++++++++++++
 tb/tb_btn_debounce.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/super_counter_pkg.sv
// Shared types for the button front-end: debounce FSM states and counter width.
package super_counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  localparam int BTN_CNT_W = 32;

endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both stages reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronizer, hold-count FSM, registered level and strobes.
// Optional auto-repeat of press_pulse while held: define BTN_AUTO_REPEAT_EN.
//
// state        | meaning
// IDLE         | released and stable
// PRESS_WAIT   | synced input high, counting toward a debounced press
// HELD         | pressed and stable
// RELEASE_WAIT | synced input low, counting toward a debounced release
module btn_debounce
  import super_counter_pkg::*;
#(
  parameter int CLOCK_HZ             = 25_000_000,
  parameter int DEBOUNCE_CYCLES      = CLOCK_HZ / 50,
  parameter bit ACTIVE_LOW           = 1'b0,
  parameter int REPEAT_DELAY_CYCLES  = CLOCK_HZ / 2,
  parameter int REPEAT_PERIOD_CYCLES = CLOCK_HZ / 10
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_bad_param
    $error("btn_debounce: cycle parameters must be >= 1");
  end

  localparam logic [BTN_CNT_W-1:0] DB_LAST = BTN_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit                   DB_ONE  = (DEBOUNCE_CYCLES == 1);

  logic btn_act;
  logic btn_s;

  assign btn_act = btn ^ ACTIVE_LOW;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_act),
    .q   (btn_s)
  );

  btn_state_t           state_q, state_d;
  logic [BTN_CNT_W-1:0] cnt_q, cnt_d;
  logic                 pressed_q, pressed_d;
  logic                 press_pulse_q, press_pulse_d;
  logic                 release_pulse_q, release_pulse_d;

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [BTN_CNT_W-1:0] RPT_DLY = BTN_CNT_W'(REPEAT_DELAY_CYCLES);
  localparam logic [BTN_CNT_W-1:0] RPT_PER = BTN_CNT_W'(REPEAT_PERIOD_CYCLES);

  // rpt counts cycles since the last press strobe; first selects delay vs period target
  logic [BTN_CNT_W-1:0] rpt_q, rpt_d, rpt_inc;
  logic                 rpt_first_q, rpt_first_d;
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pressed_d       = pressed_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (btn_s) begin
          if (DB_ONE) begin
            state_d       = HELD;
            pressed_d     = 1'b1;
            press_pulse_d = 1'b1;
            cnt_d         = '0;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = BTN_CNT_W'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d       = HELD;
          pressed_d     = 1'b1;
          press_pulse_d = 1'b1;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + BTN_CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          if (DB_ONE) begin
            state_d         = IDLE;
            pressed_d       = 1'b0;
            release_pulse_d = 1'b1;
            cnt_d           = '0;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = BTN_CNT_W'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d         = IDLE;
          pressed_d       = 1'b0;
          release_pulse_d = 1'b1;
          cnt_d           = '0;
        end else begin
          cnt_d = cnt_q + BTN_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef BTN_AUTO_REPEAT_EN
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
    rpt_inc     = rpt_q + BTN_CNT_W'(1);
    // A release straight to IDLE wins over a repeat so the two strobes never coincide
    if (state_d == IDLE) begin
      rpt_d       = '0;
      rpt_first_d = 1'b1;
    end else if ((state_q == IDLE || state_q == PRESS_WAIT) && state_d == HELD) begin
      rpt_d       = '0;
      rpt_first_d = 1'b1;
    end else if (state_q == HELD) begin
      if (rpt_inc == (rpt_first_q ? RPT_DLY : RPT_PER)) begin
        press_pulse_d = 1'b1;
        rpt_d         = '0;
        rpt_first_d   = 1'b0;
      end else begin
        rpt_d = rpt_inc;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_q           <= '0;
      rpt_first_q     <= 1'b1;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_q           <= rpt_d;
      rpt_first_q     <= rpt_first_d;
`endif
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: active-high and active-low instances share one reference model.
module tb_btn_debounce;

  localparam int DB  = 4;
  localparam int DLY = 20;
  localparam int PER = 8;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_lvl = 1'b0;
  logic btn_n;
  logic pr_a, pp_a, rp_a;
  logic pr_b, pp_b, rp_b;

  assign btn_n = ~btn_lvl;

  always #5 clk = ~clk;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1'b0),
    .REPEAT_DELAY_CYCLES(DLY), .REPEAT_PERIOD_CYCLES(PER)
  ) dut_a (
    .clk(clk), .rst(rst), .btn(btn_lvl),
    .pressed(pr_a), .press_pulse(pp_a), .release_pulse(rp_a)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1'b1),
    .REPEAT_DELAY_CYCLES(DLY), .REPEAT_PERIOD_CYCLES(PER)
  ) dut_b (
    .clk(clk), .rst(rst), .btn(btn_n),
    .pressed(pr_b), .press_pulse(pp_b), .release_pulse(rp_b)
  );

  typedef struct {
    int cyc;
    bit is_press;
  } ev_t;

  ev_t evq[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  bit  chk_en = 1'b0;

  // Reference model: level flips after DB consecutive samples that differ from it,
  // samples reach the debouncer two edges after btn is captured.
  bit  m_lvl = 1'b0;
  int  m_run = 0;
  int  m_rpt = 0;
  bit  b1 = 1'b0, b2 = 1'b0, r1 = 1'b1, r2 = 1'b1;

  always @(posedge clk) begin
    bit x;
    bit b_now;
    bit r_now;
    cyc++;
    b_now = btn_lvl;
    r_now = rst;
    if (r_now) begin
      m_lvl = 1'b0;
      m_run = 0;
      m_rpt = 0;
    end else begin
      x = (r1 || r2) ? 1'b0 : b2;
      if (AUTO && m_lvl && m_run == 0) begin
        m_rpt++;
        if (m_rpt >= DLY && ((m_rpt - DLY) % PER) == 0)
          evq.push_back('{cyc: cyc, is_press: 1'b1});
      end
      if (x != m_lvl) begin
        m_run++;
        if (m_run == DB) begin
          m_lvl = x;
          m_run = 0;
          m_rpt = 0;
          evq.push_back('{cyc: cyc, is_press: x});
        end
      end else begin
        m_run = 0;
      end
    end
    b2 = b1; b1 = b_now;
    r2 = r1; r1 = r_now;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  int n_press = 0;
  int last_press = -1;
  int last_rel = -1;

  always @(negedge clk) begin
    bit exp_p;
    bit exp_r;
    if (chk_en) begin
      exp_p = 1'b0;
      exp_r = 1'b0;
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        if (evq[0].cyc == cyc) begin
          if (evq[0].is_press) exp_p = 1'b1;
          else                 exp_r = 1'b1;
        end
        void'(evq.pop_front());
      end
      chk("a_pressed", int'(pr_a), int'(m_lvl));
      chk("a_press_pulse", int'(pp_a), int'(exp_p));
      chk("a_release_pulse", int'(rp_a), int'(exp_r));
      chk("b_pressed", int'(pr_b), int'(m_lvl));
      chk("b_press_pulse", int'(pp_b), int'(exp_p));
      chk("b_release_pulse", int'(rp_b), int'(exp_r));
      chk("a_pulse_exclusive", int'(pp_a & rp_a), 0);
      if (pp_a) begin
        n_press++;
        last_press = cyc;
      end
      if (rp_a) last_rel = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int e0;
    int np;
    int dur;
    rst = 1'b1;
    btn_lvl = 1'b0;
    step(1);
    chk_en = 1'b1;
    step(2);
    rst = 1'b0;
    step(5);

    // Clean press
    btn_lvl = 1'b1;
    e0 = cyc;
    np = n_press;
    step(10);
    chk("s1_press_edge", last_press, e0 + 6);
    chk("s1_press_count", n_press - np, 1);

    // Release after hold
    btn_lvl = 1'b0;
    e0 = cyc;
    step(10);
    chk("s4_release_edge", last_rel, e0 + 6);

    // Bounce then settle high
    np = n_press;
    btn_lvl = 1'b1; step(1);
    btn_lvl = 1'b0; step(1);
    btn_lvl = 1'b1; step(1);
    btn_lvl = 1'b0; step(1);
    btn_lvl = 1'b1;
    e0 = cyc;
    step(12);
    chk("s2_bounce_count", n_press - np, 1);
    chk("s2_bounce_edge", last_press, e0 + 6);
    btn_lvl = 1'b0;
    step(12);

    // Glitch shorter than the debounce window
    np = n_press;
    btn_lvl = 1'b1; step(3);
    btn_lvl = 1'b0; step(10);
    chk("s3_glitch_count", n_press - np, 0);

    // Reset while a press is being qualified
    btn_lvl = 1'b1;
    e0 = cyc;
    step(3);
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    e0 = cyc;
    step(10);
    chk("s5_press_after_rst", last_press, e0 + 6);
    btn_lvl = 1'b0;
    step(12);

    // Long hold: auto-repeat strobes when enabled
    np = n_press;
    btn_lvl = 1'b1;
    e0 = cyc;
    step(60);
    btn_lvl = 1'b0;
    step(20);
    chk("s6_press_count", n_press - np, AUTO ? 6 : 1);
    chk("s6_last_press", last_press, e0 + 6 + (AUTO ? 52 : 0));

    // Random bouncing, holds and resets
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        step($urandom_range(1, 3));
        rst = 1'b0;
      end else begin
        btn_lvl = 1'($urandom_range(0, 1));
        dur = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 70) : $urandom_range(1, 8);
        step(dur);
      end
    end

    btn_lvl = 1'b0;
    step(20);
    chk("queue_drained", evq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
